// File: rtl/train_sequencer_if.sv
// Control/status bundle between the train controller and the station-stop sequencer.
interface train_sequencer_if #(
    parameter int unsigned TW = 19
);
    logic          start;
    logic          at_station;
    logic          obstruct;
    logic          estop;
    logic [TW-1:0] t1;
    logic [TW-1:0] t0;
    logic [3:0]    present_state;
    logic [TW-1:0] count;
    logic          motor_en;
    logic          brake;
    logic          door_open;
    logic          cycle_done;

    modport master (
        output start, at_station, obstruct, estop, t1, t0,
        input  present_state, count, motor_en, brake, door_open, cycle_done
    );

    modport slave (
        input  start, at_station, obstruct, estop, t1, t0,
        output present_state, count, motor_en, brake, door_open, cycle_done
    );
endinterface

// File: rtl/train_sequencer.sv
// Station-stop sequencer: RUN -> BRAKE -> DOOR_OPEN -> DWELL -> DOOR_CLOSE -> RUN,
// with obstruction retry and emergency-stop override.
module train_sequencer #(
    parameter int unsigned TW = 19
) (
    input logic          clk,
    input logic          rst_n,
    train_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle      = 4'b0000,
        StRun       = 4'b0001,
        StBrake     = 4'b0010,
        StDoorOpen  = 4'b0011,
        StDwell     = 4'b0100,
        StDoorClose = 4'b0101,
        StEstop     = 4'b1111
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] count_q, count_d;
    logic          motor_q, brake_q, door_q, done_q, done_d;
    logic          expired;

    // A loaded duration of 0 or 1 both expire on the first cycle, so D=0 acts as D=1.
    always_comb begin
        state_d = StIdle;
        count_d = '0;
        done_d  = 1'b0;
        expired = (count_q <= TW'(1));
        if (bus.estop) begin
            state_d = StEstop;
        end else begin
            case (state_q)
                StEstop: state_d = StIdle;
                StIdle:  state_d = bus.start ? StRun : StIdle;
                StRun: begin
                    if (bus.at_station) begin
                        state_d = StBrake;
                        count_d = bus.t1;
                    end else begin
                        state_d = StRun;
                    end
                end
                StBrake, StDoorOpen, StDwell: begin
                    if (expired) begin
                        state_d = (state_q == StBrake) ? StDoorOpen :
                                  (state_q == StDoorOpen) ? StDwell : StDoorClose;
                        count_d = bus.t0;
                    end else begin
                        state_d = state_q;
                        count_d = count_q - TW'(1);
                    end
                end
                StDoorClose: begin
                    if (bus.obstruct) begin
                        state_d = StDoorOpen;
                        count_d = bus.t0;
                    end else if (expired) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StDoorClose;
                        count_d = count_q - TW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Actuators decode the next state so they change together with present_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            motor_q <= 1'b0;
            brake_q <= 1'b0;
            door_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            motor_q <= (state_d == StRun);
            brake_q <= (state_d == StBrake) || (state_d == StEstop);
            door_q  <= (state_d == StDoorOpen) || (state_d == StDwell);
            done_q  <= done_d;
        end
    end

    assign bus.present_state = state_q;
    assign bus.count         = count_q;
    assign bus.motor_en      = motor_q;
    assign bus.brake         = brake_q;
    assign bus.door_open     = door_q;
    assign bus.cycle_done    = done_q;
endmodule

// File: tb/tb_train_sequencer.sv
// Scoreboard bench: a phase/elapsed-time model predicts every cycle; a monitor compares.
module tb_train_sequencer;
    localparam int unsigned TW = 19;

    typedef struct packed {
        logic [3:0]    st;
        logic [TW-1:0] cnt;
        logic          motor;
        logic          brk;
        logic          door;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    train_sequencer_if #(.TW(TW)) bus ();

    train_sequencer #(.TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    // Model: mode 0 idle, 1 run, 2 in stop sequence (phase index into stop_seq), 15 estop.
    int stop_seq[4] = '{2, 3, 4, 5};
    int m_mode = 0, m_idx = 0, m_dur = 0, m_el = 0;
    bit m_done = 0;

    bit i_start = 0, i_at = 0, i_obs = 0, i_es = 0, i_rst_n = 1;
    int i_t1 = 0, i_t0 = 0;

    function automatic int m_code();
        return (m_mode == 2) ? stop_seq[m_idx] : m_mode;
    endfunction

    function automatic int m_count();
        return (m_mode == 2) ? (m_dur - m_el) : 0;
    endfunction

    task automatic enter_phase(input int idx, input int d);
        m_mode = 2;
        m_idx  = idx;
        m_dur  = d;
        m_el   = 0;
    endtask

    task automatic model_step();
        int res;
        m_done = 0;
        res = (m_dur < 1) ? 1 : m_dur;
        if (!i_rst_n) m_mode = 0;
        else if (i_es) m_mode = 15;
        else begin
            case (m_mode)
                15: m_mode = 0;
                0:  if (i_start) m_mode = 1;
                1:  if (i_at) enter_phase(0, i_t1);
                2: begin
                    if (m_idx == 3 && i_obs) enter_phase(1, i_t0);
                    else if (m_el + 1 >= res) begin
                        if (m_idx == 3) begin
                            m_mode = 1;
                            m_done = 1;
                        end else enter_phase(m_idx + 1, i_t0);
                    end else m_el++;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic step();
        exp_t e;
        int c;
        @(negedge clk);
        rst_n          = i_rst_n;
        bus.start      = i_start;
        bus.at_station = i_at;
        bus.obstruct   = i_obs;
        bus.estop      = i_es;
        bus.t1         = TW'(i_t1);
        bus.t0         = TW'(i_t0);
        model_step();
        c       = m_code();
        e.st    = 4'(c);
        e.cnt   = TW'(m_count());
        e.motor = (c == 1);
        e.brk   = (c == 2) || (c == 15);
        e.door  = (c == 3) || (c == 4);
        e.done  = m_done;
        sb.push_back(e);
    endtask

    task automatic run_until(input int target, input int limit, input string tag);
        int n = 0;
        while (m_code() != target && n < limit) begin
            step();
            n++;
        end
        tests++;
        if (m_code() != target) begin
            fails++;
            $display("FAIL %s: model state %0d, required %0d within %0d cycles",
                     tag, m_code(), target, limit);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_station();
        i_at = 1;
        step();
        i_at = 0;
    endtask

    // Monitor: every cycle the DUT presents a full status word.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {bus.present_state, bus.count, bus.motor_en, bus.brake,
                       bus.door_open, bus.cycle_done};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL status @%0t: got st=%b cnt=%0d m=%b b=%b d=%b c=%b, required st=%b cnt=%0d m=%b b=%b d=%b c=%b",
                             $time, got.st, got.cnt, got.motor, got.brk, got.door, got.done,
                             e.st, e.cnt, e.motor, e.brk, e.door, e.done);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 0; bus.at_station = 0; bus.obstruct = 0; bus.estop = 0;
        bus.t1 = '0; bus.t0 = '0;

        i_rst_n = 0;
        steps(2);
        i_rst_n = 1;
        steps(1);

        // Normal stop
        i_t1 = 5; i_t0 = 3;
        i_start = 1; step(); i_start = 0;
        pulse_station();
        steps(16);

        // Zero durations
        i_t1 = 0; i_t0 = 0;
        pulse_station();
        steps(6);

        // Obstruction in the 2nd DOOR_CLOSE cycle
        i_t1 = 2; i_t0 = 3;
        pulse_station();
        run_until(5, 30, "reach_door_close");
        step();
        i_obs = 1; step(); i_obs = 0;
        steps(14);

        // Emergency stop in the 2nd BRAKE cycle
        i_t1 = 10;
        pulse_station();
        step();
        i_es = 1; step(); i_es = 0;
        step();
        i_start = 1; step(); i_start = 0;
        steps(2);

        // Reset in DWELL with count 7
        i_t1 = 2; i_t0 = 9;
        pulse_station();
        run_until(4, 40, "reach_dwell");
        steps(2);
        tests++;
        if (m_count() != 7) begin
            fails++;
            $display("FAIL dwell_count_setup: model count %0d, required 7", m_count());
        end
        i_rst_n = 0; step(); i_rst_n = 1;
        step();

        // t0 changed mid-DOOR_OPEN
        i_t1 = 1; i_t0 = 3;
        i_start = 1; step(); i_start = 0;
        pulse_station();
        run_until(3, 20, "reach_door_open");
        step();
        i_t0 = 9;
        steps(25);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            i_rst_n = ($urandom_range(0, 99) != 0);
            i_es    = ($urandom_range(0, 39) == 0);
            i_start = ($urandom_range(0, 1) == 1);
            i_at    = ($urandom_range(0, 2) == 0);
            i_obs   = ($urandom_range(0, 5) == 0);
            i_t1    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 5);
            i_t0    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 5);
            step();
        end
        i_rst_n = 1; i_es = 0;

        @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/train_sequencer.md
# train_sequencer

Station-stop sequencer for the train controller. Holds the `present_state` register that drives the timer-value selector and the actuator decode. Runs a 19-bit countdown loaded with the braking duration `t1` or the door/dwell duration `t0`. Steps through RUN, BRAKE, DOOR_OPEN, DWELL and DOOR_CLOSE, with obstruction retry and emergency-stop override.

## Interface
Parameters:
- `TW`, 19, width of the timer durations and the countdown.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start`  in  1  level; leave IDLE and begin running.
- `at_station`  in  1  level; station sensor, sampled only in RUN.
- `obstruct`  in  1  level; door obstruction, sampled only in DOOR_CLOSE.
- `estop`  in  1  level; emergency stop, highest priority.
- `t1`  in  TW  braking duration in cycles.
- `t0`  in  TW  door/dwell duration in cycles.
- `present_state`  out  4  current state encoding, registered.
- `count`  out  TW  remaining countdown, registered.
- `motor_en`  out  1  traction enable.
- `brake`  out  1  brake command.
- `door_open`  out  1  doors open or held open.
- `cycle_done`  out  1  one-cycle pulse when a station stop completes.

## Operation
- State encodings:
  - IDLE = 0000
  - RUN = 0001
  - BRAKE = 0010
  - DOOR_OPEN = 0011
  - DWELL = 0100
  - DOOR_CLOSE = 0101
  - ESTOP = 1111
- Any other encoding transitions to IDLE on the next edge.
- Outputs are a Moore decode of the state register:
  - RUN: `motor_en` = 1.
  - BRAKE: `brake` = 1.
  - DOOR_OPEN, DWELL: `door_open` = 1.
  - ESTOP: `brake` = 1.
  - All other states: all outputs 0.
- Transitions, evaluated in priority order each edge:
  1. `estop` = 1 forces ESTOP and sets `count` = 0. This applies from every state, including ESTOP itself.
  2. ESTOP with `estop` = 0 goes to IDLE.
  3. IDLE with `start` = 1 goes to RUN.
  4. RUN with `at_station` = 1 goes to BRAKE, loading `t1`.
  5. Timed states (BRAKE, DOOR_OPEN, DWELL, DOOR_CLOSE) when expired go to:
     - BRAKE → DOOR_OPEN, loading `t0`.
     - DOOR_OPEN → DWELL, loading `t0`.
     - DWELL → DOOR_CLOSE, loading `t0`.
     - DOOR_CLOSE → RUN.
  6. DOOR_CLOSE with `obstruct` = 1 goes back to DOOR_OPEN and reloads `t0`. This applies whether or not the timer has expired; obstruct beats expiry.
- Countdown:
  - `count` is loaded on the same edge that enters a timed state.
  - The timer source follows `present_state`: 0010 loads `t1`; 0011, 0100 and 0101 load `t0`.
  - In a timed state the state is expired when `count` ≤ 1. Otherwise `count` decrements by 1 per cycle.
  - `count` becomes 0 on entering any untimed state.
  - A loaded duration D gives a residence of max(D, 1) cycles. D = 0 behaves as D = 1.
  - `t1` and `t0` are sampled only at load. Changes mid-state have no effect.
  - No wrap-around: `count` never decrements below 1 inside a timed state.
- `cycle_done` is registered. It is 1 for exactly the cycle after the DOOR_CLOSE → RUN edge, i.e. the first cycle in RUN.

## Timing
- Reset (`rst_n` = 0 at an edge) forces:
  - `present_state` = 0000, `count` = 0.
  - `motor_en`, `brake`, `door_open`, `cycle_done` all 0.
- Reset takes effect at any point mid-sequence, with priority over `estop`.
- Inputs take effect on the first edge at which they are sampled. Output change is visible one cycle after the input is asserted.
- Actuator outputs change in the same cycle as `present_state`, with no extra latency.
- RUN with `at_station` held high re-enters BRAKE only after completing the full stop cycle. This requires a fresh RUN cycle with `at_station` still 1.
- A full stop with no obstruction occupies max(t1,1) + 3·max(t0,1) cycles from BRAKE entry to RUN entry.

## Test plan
- **Normal stop.** Reset, `start` = 1, then `at_station` = 1 for one cycle, with `t1` = 5, `t0` = 3. Required: states run 0001 → 0010 for 5 cycles (`count` 5,4,3,2,1) → 0011 ×3 → 0100 ×3 → 0101 ×3 → 0001. `cycle_done` = 1 for exactly the first RUN cycle.
- **Zero durations.** `t1` = 0, `t0` = 0. Required: each timed state lasts exactly 1 cycle, and BRAKE entry to RUN entry takes 4 cycles.
- **Obstruction.** `obstruct` = 1 during the 2nd cycle of DOOR_CLOSE with `t0` = 3. Required: next state 0011 with `count` = 3 and `door_open` = 1. The sequence then completes normally once `obstruct` = 0.
- **Emergency stop.** `estop` = 1 in the 2nd cycle of BRAKE with `t1` = 10. Required: next cycle 1111, `brake` = 1, `count` = 0. Releasing `estop` gives 0000 on the following cycle. `start` then gives 0001.
- **Mid-operation events.** Assert `rst_n` = 0 for one cycle in DWELL with `count` = 7. Required: next cycle has all outputs at their reset values. Separately, change `t0` from 3 to 9 mid-DOOR_OPEN: the current state still lasts 3 cycles, and DWELL then loads 9.
